// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit.
// Op encodings follow the Execute-stage OpE field.
// FSM states are shared by the sequencer and any bench that wants to name them.
package mips_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Operand latch plus one-bit-per-step shift-add multiply / restoring divide.
// Latency: one step per cycle while step=1; result is combinational from state.
// No backpressure: init and step are strobes from the sequencer FSM.
module muldiv_datapath
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  init,
  input  logic                  step,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic [DATA_WIDTH-1:0] res_hi,
  output logic [DATA_WIDTH-1:0] res_lo
);

  localparam int W = DATA_WIDTH;

  logic         is_div_q, is_div_d;
  logic         sign_a_q, sign_a_d;
  logic         sign_b_q, sign_b_d;
  logic         b_zero_q, b_zero_d;
  logic [W-1:0] a_raw_q, a_raw_d;
  logic [W-1:0] b_mag_q, b_mag_d;
  // hi: product accumulator / remainder; lo: multiplier bits / dividend-quotient
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;

  logic         is_signed;
  logic [W:0]   sum;
  logic [W:0]   shifted;
  logic [W:0]   trial;

  // Operand latch on init, one multiply or divide iteration on step
  always_comb begin
    is_div_d  = is_div_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    b_zero_d  = b_zero_q;
    a_raw_d   = a_raw_q;
    b_mag_d   = b_mag_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag_q} : '0);
    shifted   = {hi_q, lo_q[W-1]};
    trial     = shifted - {1'b0, b_mag_q};
    if (init) begin
      is_div_d = (op == MDU_DIV) || (op == MDU_DIVU);
      sign_a_d = is_signed & src_a[W-1];
      sign_b_d = is_signed & src_b[W-1];
      b_zero_d = (src_b == '0);
      a_raw_d  = src_a;
      lo_d     = (is_signed & src_a[W-1]) ? -src_a : src_a;
      b_mag_d  = (is_signed & src_b[W-1]) ? -src_b : src_b;
      hi_d     = '0;
    end else if (step) begin
      if (is_div_q) begin
        // Trial subtract succeeds when no borrow out of the top bit
        if (!trial[W]) begin
          hi_d = trial[W-1:0];
          lo_d = {lo_q[W-2:0], 1'b1};
        end else begin
          hi_d = shifted[W-1:0];
          lo_d = {lo_q[W-2:0], 1'b0};
        end
      end else begin
        {hi_d, lo_d} = {sum, lo_q[W-1:1]};
      end
    end
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      a_raw_q  <= '0;
      b_mag_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      a_raw_q  <= a_raw_d;
      b_mag_q  <= b_mag_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Sign correction; divide-by-zero returns all-ones quotient and raw dividend.
  // Most-negative / -1 needs no special case: magnitude quotient 2^(W-1) negates to itself.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    if (!is_div_q) begin
      if (sign_a_q ^ sign_b_q) {res_hi, res_lo} = -{hi_q, lo_q};
    end else if (b_zero_q) begin
      res_hi = a_raw_q;
      res_lo = '1;
    end else begin
      res_lo = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
      res_hi = sign_a_q ? -hi_q : hi_q;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS HI/LO owner: sequences MULT/MULTU/DIV/DIVU through the iterative datapath.
// Latency: DATA_WIDTH+2 edges from the start edge to HI/LO visible.
// Backpressure: StallMDU holds MFHI/MFLO and any new start while Busy.
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  StartE,
  input  logic [1:0]            OpE,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  logic                  AbortE,
  input  logic                  ReadHiLoD,
  input  logic                  WriteHiW,
  input  logic                  WriteLoW,
  input  logic [DATA_WIDTH-1:0] WriteDataW,
  output logic                  Busy,
  output logic                  StallMDU,
  output logic                  DoneM,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  mdu_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic                  init, step, fix;
  logic [DATA_WIDTH-1:0] res_hi, res_lo;

  muldiv_datapath #(.DATA_WIDTH(DATA_WIDTH)) u_dp (
    .CLK    (CLK),
    .RST    (RST),
    .init   (init),
    .step   (step),
    .op     (OpE),
    .src_a  (SrcAE),
    .src_b  (SrcBE),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // FSM next state and datapath strobes; abort wins in every busy state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    init    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (StartE && !AbortE) begin
          state_d = MDU_RUN;
          cnt_d   = '0;
          init    = 1'b1;
        end
      end
      MDU_RUN: begin
        if (AbortE) begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
            state_d = MDU_FIX;
            cnt_d   = '0;
          end
        end
      end
      MDU_FIX: begin
        state_d = MDU_IDLE;
        if (!AbortE) begin
          fix    = 1'b1;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // HI/LO update: MTHI/MTLO override the FIX result for their own register
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (fix) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
    if (WriteHiW) hi_d = WriteDataW;
    if (WriteLoW) lo_d = WriteDataW;
  end

  // State, counter, done pulse and HI/LO registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy     = (state_q != MDU_IDLE);
  assign StallMDU = Busy & (ReadHiLoD | StartE);
  assign DoneM    = done_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit for the 5-stage MIPS pipeline. It provides MULT, MULTU, DIV and DIVU, and owns the HI/LO registers.
- It accepts an operation from the Execute stage and runs a one-bit-per-cycle FSM (shift-add multiply, restoring divide).
- It drives a stall request that the hazard unit ORs into StallF/StallD, and into the E-stage hold, while a result is pending.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- StartE  in  1  valid MULT/MULTU/DIV/DIVU in Execute stage.
- OpE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcAE  in  DATA_WIDTH  rs operand (multiplicand/dividend).
- SrcBE  in  DATA_WIDTH  rt operand (multiplier/divisor).
- AbortE  in  1  exception flush: kill in-flight operation.
- ReadHiLoD  in  1  MFHI/MFLO in Decode stage.
- WriteHiW  in  1  MTHI write-back.
- WriteLoW  in  1  MTLO write-back.
- WriteDataW  in  DATA_WIDTH  MTHI/MTLO data.
- Busy  out  1  operation in flight.
- StallMDU  out  1  stall request to hazard unit.
- DoneM  out  1  one-cycle pulse: HI/LO just updated by an operation.
- HI  out  DATA_WIDTH  HI register.
- LO  out  DATA_WIDTH  LO register.

Behaviour:
- Reset (sync, RST=1 at an edge):
  - state IDLE; counter 0; HI=LO=0; Busy=0; DoneM=0.
  - An in-flight operation is discarded.
- States: IDLE, RUN, FIX.
  - IDLE -> RUN on StartE & !AbortE.
  - RUN holds for DATA_WIDTH edges, counter 0..DATA_WIDTH-1.
  - RUN -> FIX when counter == DATA_WIDTH-1.
  - FIX -> IDLE unconditionally.
- Start edge e0:
  - Latch op, sign of A, sign of B, and |A|, |B| (magnitudes used only for signed ops).
  - Clear partial accumulator/remainder.
- RUN:
  - Multiply: one shift-add step per cycle on the 2*DATA_WIDTH product.
  - Divide: one restoring step per cycle (shift remainder, trial subtract, set quotient bit).
- FIX (edge e(DATA_WIDTH+1)):
  - Apply sign correction, then write HI/LO.
  - Multiply: HI:LO = product. Signed result is negated if signA^signB.
  - Divide: LO = quotient, negated if signA^signB (signed only). HI = remainder, negated if signA (signed only).
  - Total latency is DATA_WIDTH+2 edges from the start edge to HI/LO visible (34 at default).
- Busy=1 in RUN and FIX, 0 otherwise.
- DoneM=1 in the cycle following the FIX edge only.
- StallMDU is combinational: Busy & (ReadHiLoD | StartE).
  - A StartE arriving while Busy is held off. It is not accepted until IDLE.
  - StartE in IDLE does not stall.
  - A MFHI in Decode in the same cycle as start is stalled next cycle via Busy.
- Divide by zero (B==0): LO = all ones, HI = SrcA as latched (raw, not magnitude). Sign correction is skipped for both signed and unsigned.
- Signed overflow (most-negative / -1): LO = 0x80000000, HI = 0. No trap.
- AbortE:
  - In RUN or FIX: return to IDLE next edge; HI/LO unchanged; no DoneM.
  - Abort on the start edge: the start is not accepted.
- MTHI/MTLO:
  - Write HI/LO on any edge.
  - If coincident with the FIX edge, the MT write wins for its register. The other register takes the FIX result.

Decomposition:
- Shared package mips_pkg: op encodings (MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11) and FSM state localparams.
- One sub-module is natural: muldiv_datapath (accumulator/remainder registers and step logic), driven by the FSM in muldiv_sequencer via init/step/fix strobes.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> after 34 edges HI=0xFFFFFFFE, LO=0x00000001; DoneM one cycle; Busy high exactly 33 cycles.
- MULT -3 * 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- ReadHiLoD=1 held from start -> StallMDU=1 every cycle Busy=1, drops the cycle after FIX; second StartE during RUN -> StallMDU=1, op begins only after return to IDLE.
- AbortE at RUN cycle 10 after prior HI=0x11, LO=0x22 -> IDLE next edge, HI/LO unchanged, no DoneM; RST at RUN cycle 5 -> HI=LO=0, Busy=0 next cycle.
- MTLO 0xABCD on the FIX edge of MULTU 2*3 -> LO=0xABCD, HI=0.
